bcd_entry_buffer: RTL and testbench



---
 rtl/bcd_entry_buffer_if.sv | 51 +++++
 rtl/bcd_entry_buffer.sv | 149 ++++++++++++++
 tb/tb_bcd_entry_buffer.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_entry_buffer_if.sv
// Keypad/result/operand bundle for the BCD operand-entry buffer.
// slave: the buffer itself; master: the keypad/sequencer side driving it.
interface bcd_entry_buffer_if #(
    parameter int DIGITS = 10
);
    localparam int CW = $clog2(DIGITS + 1);

    // keypad levels (edge-detected inside the buffer)
    logic                  new_digit;
    logic [3:0]            digit;
    logic                  backspace;
    logic                  neg_toggle;
    logic                  clear;
    logic                  commit;

    // previous-result load (single-cycle strobe)
    logic                  load_result;
    logic [4*DIGITS-1:0]   result_bcd;
    logic [CW-1:0]         result_count;
    logic                  result_neg;

    // live entry view
    logic [4*DIGITS-1:0]   num_bcd;
    logic [CW-1:0]         count;
    logic                  negative;
    logic                  full;
    logic                  err;

    // committed operand handshake
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   out_bcd;
    logic [CW-1:0]         out_count;
    logic                  out_neg;

    modport slave (
        input  new_digit, digit, backspace, neg_toggle, clear, commit,
        input  load_result, result_bcd, result_count, result_neg,
        input  out_ready,
        output num_bcd, count, negative, full, err,
        output out_valid, out_bcd, out_count, out_neg
    );

    modport master (
        output new_digit, digit, backspace, neg_toggle, clear, commit,
        output load_result, result_bcd, result_count, result_neg,
        output out_ready,
        input  num_bcd, count, negative, full, err,
        input  out_valid, out_bcd, out_count, out_neg
    );
endinterface

// File: rtl/bcd_entry_buffer.sv
// BCD operand-entry buffer: collects keypad digits into a packed BCD number
// (digit 0 in [3:0]), supports backspace/sign/clear/result load, and hands
// committed operands out over a valid/ready handshake.
module bcd_entry_buffer #(
    parameter int DIGITS = 10
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    bcd_entry_buffer_if.slave bus
);
    localparam int            CW       = $clog2(DIGITS + 1);
    localparam int            NW       = 4 * DIGITS;
    localparam logic [CW-1:0] FULL_CNT = CW'(DIGITS);

    // bit positions in the shared edge-detect vector
    localparam int K_DIG = 0;
    localparam int K_BS  = 1;
    localparam int K_NEG = 2;
    localparam int K_CLR = 3;
    localparam int K_CMT = 4;

    logic [4:0]    w_lvl;
    logic [4:0]    w_evt;
    logic [4:0]    r_prev;
    logic          r_armed;   // low for the first clock after reset

    logic [NW-1:0] r_num,  w_num;
    logic [CW-1:0] r_cnt,  w_cnt;
    logic          r_neg,  w_neg;
    logic          r_err,  w_err;
    logic          r_ov,   w_ov;
    logic [NW-1:0] r_obcd, w_obcd;
    logic [CW-1:0] r_ocnt, w_ocnt;
    logic          r_oneg, w_oneg;
    logic          w_take;

    assign w_lvl = {bus.commit, bus.clear, bus.neg_toggle, bus.backspace, bus.new_digit};
    // A key held across reset release must not fire: the first clock only
    // captures the levels.
    assign w_evt = w_lvl & ~r_prev & {5{r_armed}};

    // previous-value registers for rising-edge detection
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prev  <= '0;
            r_armed <= 1'b0;
        end else begin
            r_prev  <= w_lvl;
            r_armed <= 1'b1;
        end
    end

    // one action per cycle, highest-priority event wins, the rest are dropped
    always_comb begin
        w_num  = r_num;
        w_cnt  = r_cnt;
        w_neg  = r_neg;
        w_err  = r_err;
        w_ov   = r_ov;
        w_obcd = r_obcd;
        w_ocnt = r_ocnt;
        w_oneg = r_oneg;
        w_take = r_ov & bus.out_ready;

        if (w_take)
            w_ov = 1'b0;

        if (w_evt[K_CLR]) begin
            w_num = '0;
            w_cnt = '0;
            w_neg = 1'b0;
            w_err = 1'b0;
        end else if (bus.load_result) begin
            w_num = bus.result_bcd;
            for (int i = 0; i < DIGITS; i++)
                if (i >= int'(bus.result_count))
                    w_num[4*i +: 4] = 4'd0;
            if (int'(bus.result_count) > DIGITS) begin
                w_cnt = FULL_CNT;
                w_err = 1'b1;
            end else begin
                w_cnt = bus.result_count;
            end
            w_neg = bus.result_neg;
        end else if (w_evt[K_CMT]) begin
            // slot is free, or is being drained this very cycle
            if (!r_ov || bus.out_ready) begin
                w_obcd = r_num;
                w_ocnt = r_cnt;
                w_oneg = r_neg;
                w_ov   = 1'b1;
                w_num  = '0;
                w_cnt  = '0;
                w_neg  = 1'b0;
            end else begin
                w_err = 1'b1;
            end
        end else if (w_evt[K_BS]) begin
            if (r_cnt != '0) begin
                w_num = {4'd0, r_num[NW-1:4]};
                w_cnt = r_cnt - CW'(1);
                if (r_cnt == CW'(1))
                    w_neg = 1'b0;
            end
        end else if (w_evt[K_NEG]) begin
            w_neg = ~r_neg;
        end else if (w_evt[K_DIG]) begin
            if (bus.digit > 4'd9 || r_cnt == FULL_CNT) begin
                w_err = 1'b1;
            end else if (!(r_cnt == '0 && bus.digit == 4'd0)) begin
                w_num = {r_num[NW-5:0], bus.digit};
                w_cnt = r_cnt + CW'(1);
            end
        end
    end

    // entry and committed-operand state
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_num  <= '0;
            r_cnt  <= '0;
            r_neg  <= 1'b0;
            r_err  <= 1'b0;
            r_ov   <= 1'b0;
            r_obcd <= '0;
            r_ocnt <= '0;
            r_oneg <= 1'b0;
        end else begin
            r_num  <= w_num;
            r_cnt  <= w_cnt;
            r_neg  <= w_neg;
            r_err  <= w_err;
            r_ov   <= w_ov;
            r_obcd <= w_obcd;
            r_ocnt <= w_ocnt;
            r_oneg <= w_oneg;
        end
    end

    assign bus.num_bcd   = r_num;
    assign bus.count     = r_cnt;
    assign bus.negative  = r_neg;
    assign bus.full      = (r_cnt == FULL_CNT);
    assign bus.err       = r_err;
    assign bus.out_valid = r_ov;
    assign bus.out_bcd   = r_obcd;
    assign bus.out_count = r_ocnt;
    assign bus.out_neg   = r_oneg;
endmodule

// File: tb/tb_bcd_entry_buffer.sv
// Bench for bcd_entry_buffer (DIGITS=4): directed scenarios plus random key
// activity, every cycle checked against a digit-queue reference model.
module tb_bcd_entry_buffer;
    localparam int D = 4;

    logic clk;
    logic rst_n;

    bcd_entry_buffer_if #(.DIGITS(D)) bus();

    bcd_entry_buffer #(.DIGITS(D)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    // reference model: entry digits most-significant first
    int             q[$];
    bit             m_neg, m_err, m_ov, m_oneg, m_started;
    logic [4*D-1:0] m_obcd;
    int             m_ocnt;
    bit             p_nd, p_bs, p_ng, p_cl, p_cm;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [4*D-1:0] pack_q();
        logic [4*D-1:0] r;
        r = '0;
        for (int i = 0; i < q.size(); i++)
            r[4*i +: 4] = 4'(q[q.size()-1-i]);
        return r;
    endfunction

    task automatic model_reset();
        q.delete();
        m_neg = 0; m_err = 0; m_ov = 0; m_oneg = 0; m_started = 0;
        m_obcd = '0; m_ocnt = 0;
        p_nd = 0; p_bs = 0; p_ng = 0; p_cl = 0; p_cm = 0;
    endtask

    task automatic model_step();
        bit e_nd, e_bs, e_ng, e_cl, e_cm, ov_before;
        int c;
        e_nd = bus.new_digit  && !p_nd && m_started;
        e_bs = bus.backspace  && !p_bs && m_started;
        e_ng = bus.neg_toggle && !p_ng && m_started;
        e_cl = bus.clear      && !p_cl && m_started;
        e_cm = bus.commit     && !p_cm && m_started;
        p_nd = bus.new_digit; p_bs = bus.backspace; p_ng = bus.neg_toggle;
        p_cl = bus.clear;     p_cm = bus.commit;
        m_started = 1;
        ov_before = m_ov;
        if (m_ov && bus.out_ready) m_ov = 0;
        if (e_cl) begin
            q.delete(); m_neg = 0; m_err = 0;
        end else if (bus.load_result) begin
            c = int'(bus.result_count);
            if (c > D) begin c = D; m_err = 1; end
            q.delete();
            for (int i = c - 1; i >= 0; i--) q.push_back(int'(bus.result_bcd[4*i +: 4]));
            m_neg = bus.result_neg;
        end else if (e_cm) begin
            if (!ov_before || bus.out_ready) begin
                m_obcd = pack_q(); m_ocnt = q.size(); m_oneg = m_neg; m_ov = 1;
                q.delete(); m_neg = 0;
            end else begin
                m_err = 1;
            end
        end else if (e_bs) begin
            if (q.size() > 0) begin
                void'(q.pop_back());
                if (q.size() == 0) m_neg = 0;
            end
        end else if (e_ng) begin
            m_neg = !m_neg;
        end else if (e_nd) begin
            if (bus.digit > 9 || q.size() == D) m_err = 1;
            else if (!(q.size() == 0 && bus.digit == 0)) q.push_back(int'(bus.digit));
        end
    endtask

    task automatic check_all();
        chk("num_bcd",   64'(bus.num_bcd),   64'(pack_q()));
        chk("count",     64'(bus.count),     64'(q.size()));
        chk("negative",  64'(bus.negative),  64'(m_neg));
        chk("full",      64'(bus.full),      64'(q.size() == D));
        chk("err",       64'(bus.err),       64'(m_err));
        chk("out_valid", 64'(bus.out_valid), 64'(m_ov));
        chk("out_bcd",   64'(bus.out_bcd),   64'(m_obcd));
        chk("out_count", 64'(bus.out_count), 64'(m_ocnt));
        chk("out_neg",   64'(bus.out_neg),   64'(m_oneg));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic idle();
        bus.new_digit = 0; bus.digit = '0; bus.backspace = 0; bus.neg_toggle = 0;
        bus.clear = 0; bus.commit = 0; bus.load_result = 0; bus.result_bcd = '0;
        bus.result_count = '0; bus.result_neg = 0; bus.out_ready = 0;
    endtask

    task automatic key_digit(input logic [3:0] d);
        bus.digit = d; bus.new_digit = 1; tick();
        bus.new_digit = 0; tick();
    endtask

    task automatic key_bs();
        bus.backspace = 1; tick(); bus.backspace = 0; tick();
    endtask

    task automatic key_commit();
        bus.commit = 1; tick(); bus.commit = 0; tick();
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        idle();
        model_reset();
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        check_all();                          // reset state
        rst_n = 1;
        tick();                               // arming cycle

        // digit entry, leading zero, overflow
        key_digit(0); key_digit(1); key_digit(2); key_digit(3);
        chk("dir_123", 64'(bus.num_bcd), 64'h123);
        chk("dir_cnt3", 64'(bus.count), 64'd3);
        key_digit(4); key_digit(5);
        chk("dir_1234", 64'(bus.num_bcd), 64'h1234);
        chk("dir_full", 64'(bus.full), 64'd1);
        chk("dir_ovf_err", 64'(bus.err), 64'd1);

        // held key gives one event; non-BCD digit flags error
        bus.clear = 1; tick(); bus.clear = 0; tick();
        bus.digit = 4'd7; bus.new_digit = 1;
        repeat (5) tick();
        bus.new_digit = 0; tick();
        chk("dir_hold7", 64'(bus.num_bcd), 64'h7);
        key_digit(4'hA);
        chk("dir_badd", 64'(bus.num_bcd), 64'h7);
        chk("dir_badd_err", 64'(bus.err), 64'd1);

        // backspace with sign
        bus.clear = 1; tick(); bus.clear = 0; tick();
        key_digit(1); key_digit(2); key_digit(3);
        bus.neg_toggle = 1; tick(); bus.neg_toggle = 0; tick();
        key_bs(); key_bs();
        chk("dir_bs_neg", 64'(bus.negative), 64'd1);
        key_bs();
        chk("dir_bs_pos", 64'(bus.negative), 64'd0);
        key_bs();
        chk("dir_bs_nop", 64'(bus.count), 64'd0);

        // result load, normal and oversize
        bus.load_result = 1; bus.result_bcd = 16'h9876; bus.result_count = 3'd2; bus.result_neg = 1;
        tick(); bus.load_result = 0;
        chk("dir_ld76", 64'(bus.num_bcd), 64'h76);
        bus.load_result = 1; bus.result_count = 3'd5; tick(); bus.load_result = 0;
        chk("dir_ld_cnt", 64'(bus.count), 64'd4);

        // commit handshake
        bus.clear = 1; tick(); bus.clear = 0; tick();
        key_digit(4); key_digit(2);
        key_commit();
        chk("dir_ob42", 64'(bus.out_bcd), 64'h42);
        key_digit(7);
        key_commit();
        chk("dir_keep7", 64'(bus.num_bcd), 64'h7);
        bus.out_ready = 1; bus.commit = 1; tick();
        bus.out_ready = 0; bus.commit = 0; tick();
        chk("dir_ob7", 64'(bus.out_bcd), 64'h7);
        bus.out_ready = 1; tick(); bus.out_ready = 0; tick();

        // clear beats digit in the same cycle
        key_digit(3);
        bus.clear = 1; bus.digit = 4'd5; bus.new_digit = 1; tick();
        bus.clear = 0; bus.new_digit = 0; tick();

        // asynchronous reset mid-entry with a pending operand
        key_digit(6); key_commit(); key_digit(8);
        #2 rst_n = 0;
        #1;
        model_reset();
        check_all();
        bus.new_digit = 1; bus.digit = 4'd9;  // held through reset release
        @(negedge clk); rst_n = 1;
        tick(); tick();
        bus.new_digit = 0; tick();

        // random activity
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 2) == 0) bus.new_digit  = ~bus.new_digit;
            if ($urandom_range(0, 5) == 0) bus.backspace  = ~bus.backspace;
            if ($urandom_range(0, 5) == 0) bus.neg_toggle = ~bus.neg_toggle;
            if ($urandom_range(0, 4) == 0) bus.commit     = ~bus.commit;
            bus.clear       = ($urandom_range(0, 24) == 0);
            bus.load_result = ($urandom_range(0, 19) == 0);
            bus.digit       = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                           : 4'($urandom_range(0, 9));
            bus.out_ready   = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < D; i++) bus.result_bcd[4*i +: 4] = 4'($urandom_range(0, 9));
            bus.result_count = 3'($urandom_range(0, 7));
            bus.result_neg   = 1'($urandom_range(0, 1));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
